// File: rtl/blink_indicator_if.sv
// Event/LED bundle for blink_indicator. The master drives the event side
// and observes the LED status. The slave is the blink engine.
interface blink_indicator_if #(
  parameter int MAX_PENDING = 7
);
  localparam int PW = $clog2(MAX_PENDING + 1);

  logic          enable;
  logic          event_pulse;
  logic          clr_overflow;
  logic          led;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  modport master (
    output enable, event_pulse, clr_overflow,
    input  led, busy, pending, overflow
  );

  modport slave (
    input  enable, event_pulse, clr_overflow,
    output led, busy, pending, overflow
  );
endinterface

// File: rtl/blink_indicator.sv
// Turns single-cycle event pulses into fixed-length LED blinks.
// Events that arrive during a blink are queued in a saturating counter.
// They are then replayed back-to-back, and each blink is followed by a
// guaranteed dark gap.
module blink_indicator #(
  parameter int ON_CYCLES   = 5_000_000,
  parameter int OFF_CYCLES  = 5_000_000,
  parameter int MAX_PENDING = 7
) (
  input  logic              clk,
  input  logic              rst,
  blink_indicator_if.slave  bus
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int PW   = $clog2(MAX_PENDING + 1);

  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          overflow_q, overflow_d;
  logic          led_q, led_d;
  logic          busy_q, busy_d;

  logic ev, have_pend, slot, start, dec, inc, drop;

  // Event bookkeeping: decide blink start, queue push/pop and overflow.
  always_comb begin
    ev        = bus.enable & bus.event_pulse;
    have_pend = (pending_q != '0);
    // A blink may begin from IDLE or on the last OFF cycle (no idle gap).
    slot      = (state_q == S_IDLE) || ((state_q == S_OFF) && (cnt_q == '0));
    start     = bus.enable && slot && (ev || have_pend);
    // Queue has priority: a start with work pending pops the queue, and any
    // coincident pulse is pushed behind it instead of being consumed.
    dec       = start && have_pend;
    inc       = ev && !(start && !have_pend);
    drop      = inc && !dec && (pending_q == PEND_MAX);

    pending_d = pending_q;
    if (!bus.enable)         pending_d = '0;
    else if (inc && !dec && !drop) pending_d = pending_q + 1'b1;
    else if (dec && !inc)    pending_d = pending_q - 1'b1;

    // A set wins over a coincident clear. Overflow is kept when disabled.
    overflow_d = overflow_q;
    if (drop)                  overflow_d = 1'b1;
    else if (bus.clr_overflow) overflow_d = 1'b0;
  end

  // Next-state: shared down-counter times both the ON and OFF phases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_ON;
            cnt_d   = ON_LOAD;
          end
        end
        S_ON: begin
          if (cnt_q == '0) begin
            state_d = S_OFF;
            cnt_d   = OFF_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_OFF: begin
          if (cnt_q == '0) begin
            if (start) begin
              state_d = S_ON;
              cnt_d   = ON_LOAD;
            end else begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so led/busy can be registered
  // and still track the state with no extra cycle of latency.
  always_comb begin
    led_d  = (state_d == S_ON);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset truncates any blink immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.led      = led_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;

endmodule
